// File: rtl/expu_sum_accumulator.sv
// expu_sum_accumulator
// Softmax denominator accumulator. It sits behind the exponential unit and
// turns each strobed exp result into unsigned fixed point. It adds up the lanes
// of a beat and keeps adding across beats until a beat flagged last arrives.
// The finished sum is then offered on a valid/ready output and held there until
// downstream takes it.
//
// The input format defaults to FP16ALT (bfloat16: 1 sign, 8 exponent and
// 7 mantissa bits, bias 127). WIDTH and BIAS are derived from EXP_BITS and
// MANT_BITS.
//
// Ports
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   clear_i     synchronous clear; highest priority, ignores enable_i
//   enable_i    global enable; when low all state is frozen
//   valid_i     input beat valid
//   ready_o     input beat accepted on valid_i & ready_o
//   strb_i      per-lane strobes; an unstrobed lane contributes 0
//   last_i      final beat of the vector
//   op_i        exp results, packed [N_ROWS-1:0][WIDTH-1:0]
//   sum_o       accumulated sum, ACC_FRACTION fraction bits
//   valid_o     sum_o valid
//   ready_i     downstream accepts the sum
//   overflow_o  saturation happened in this vector (qualified by valid_o)
//   invalid_o   a negative, Inf or NaN lane was seen (qualified by valid_o)
//   busy_o      a vector is in progress or a result is pending
module expu_sum_accumulator #(
    parameter int EXP_BITS     = 8,
    parameter int MANT_BITS    = 7,
    parameter int N_ROWS       = 1,
    parameter int ACC_INT_BITS = 16,
    parameter int ACC_FRACTION = 16,
    localparam int WIDTH       = 1 + EXP_BITS + MANT_BITS,
    localparam int ACC_WIDTH   = ACC_INT_BITS + ACC_FRACTION
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           enable_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [N_ROWS-1:0]              strb_i,
    input  logic                           last_i,
    input  logic [N_ROWS-1:0][WIDTH-1:0]   op_i,
    output logic [ACC_WIDTH-1:0]           sum_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic                           overflow_o,
    output logic                           invalid_o,
    output logic                           busy_o
);

    localparam int BIAS   = (2 ** (EXP_BITS - 1)) - 1;
    localparam int SUM_W  = ACC_WIDTH + $clog2(N_ROWS);
    localparam int SHW    = EXP_BITS + 8;
    // A biased exponent e maps to shift amount e - OFFSET.
    localparam int OFFSET = BIAS + MANT_BITS - ACC_FRACTION;
    // Largest left shift that keeps the (MANT_BITS+1)-bit significand inside
    // the accumulator.
    localparam logic signed [SHW-1:0] MAX_SH = SHW'(ACC_WIDTH - MANT_BITS - 1);
    // At or below this right shift every significand bit falls off.
    localparam logic signed [SHW-1:0] MIN_SH = -SHW'(MANT_BITS + 1);

    typedef enum logic {ACCUM, HOLD} state_e;

    // Converts one lane to fixed point. The result is {invalid, overflow, value}.
    function automatic logic [ACC_WIDTH+1:0] lane_to_fixed(input logic             strb,
                                                           input logic [WIDTH-1:0] x);
        logic                  sign;
        logic [EXP_BITS-1:0]   e;
        logic [MANT_BITS-1:0]  m;
        logic [ACC_WIDTH-1:0]  sig;
        logic [ACC_WIDTH-1:0]  val;
        logic signed [SHW-1:0] sh;
        logic [SHW-1:0]        amt;
        logic                  inv;
        logic                  ovf;
        sign = x[WIDTH-1];
        e    = x[WIDTH-2 -: EXP_BITS];
        m    = x[MANT_BITS-1:0];
        sig  = {{(ACC_WIDTH-MANT_BITS-1){1'b0}}, 1'b1, m};
        sh   = $signed({{(SHW-EXP_BITS){1'b0}}, e}) - SHW'(OFFSET);
        amt  = '0;
        val  = '0;
        inv  = 1'b0;
        ovf  = 1'b0;
        if (!strb || e == '0) begin
            val = '0;
        end else if (sign || e == '1) begin
            inv = 1'b1;
        end else if (sh > MAX_SH) begin
            ovf = 1'b1;
            val = '1;
        end else if (sh >= 0) begin
            amt = sh;
            val = sig << amt;
        end else if (sh <= MIN_SH) begin
            val = '0;
        end else begin
            amt = -sh;
            val = sig >> amt;
        end
        return {inv, ovf, val};
    endfunction

    // acc + beat, clamped to the accumulator range. The result is {saturated, value}.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [SUM_W-1:0]     b);
        logic [SUM_W:0] full;
        full = {{(SUM_W+1-ACC_WIDTH){1'b0}}, a} + {1'b0, b};
        if (full > (SUM_W+1)'({ACC_WIDTH{1'b1}})) begin
            return {1'b1, {ACC_WIDTH{1'b1}}};
        end
        return {1'b0, full[ACC_WIDTH-1:0]};
    endfunction

    state_e                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic                   inv_q, inv_d;
    logic                   started_q, started_d;
    logic [ACC_WIDTH-1:0]   sum_q, sum_d;
    logic                   ovf_out_q, ovf_out_d;
    logic                   inv_out_q, inv_out_d;

    logic [SUM_W-1:0]       beat_sum;
    logic                   beat_ovf;
    logic                   beat_inv;
    logic [ACC_WIDTH:0]     acc_sat;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic                   ovf_next;
    logic                   inv_next;
    logic                   accept;

    // Lane conversion and beat reduction.
    always_comb begin
        logic [ACC_WIDTH+1:0] conv;
        beat_sum = '0;
        beat_ovf = 1'b0;
        beat_inv = 1'b0;
        for (int i = 0; i < N_ROWS; i++) begin
            conv     = lane_to_fixed(strb_i[i], op_i[i]);
            beat_sum = beat_sum + SUM_W'(conv[ACC_WIDTH-1:0]);
            beat_ovf = beat_ovf | conv[ACC_WIDTH];
            beat_inv = beat_inv | conv[ACC_WIDTH+1];
        end
    end

    assign acc_sat  = sat_add(acc_q, beat_sum);
    assign acc_next = acc_sat[ACC_WIDTH-1:0];
    assign ovf_next = ovf_q | beat_ovf | acc_sat[ACC_WIDTH];
    assign inv_next = inv_q | beat_inv;

    assign ready_o  = (state_q == ACCUM) && enable_i;
    assign accept   = valid_i && ready_o;

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        inv_d     = inv_q;
        started_d = started_q;
        sum_d     = sum_q;
        ovf_out_d = ovf_out_q;
        inv_out_d = inv_out_q;
        if (clear_i) begin
            state_d   = ACCUM;
            acc_d     = '0;
            ovf_d     = 1'b0;
            inv_d     = 1'b0;
            started_d = 1'b0;
            ovf_out_d = 1'b0;
            inv_out_d = 1'b0;
        end else if (enable_i) begin
            unique case (state_q)
                ACCUM: begin
                    if (accept) begin
                        if (last_i) begin
                            // Publish the result and leave the accumulator
                            // clean for the next vector.
                            state_d   = HOLD;
                            sum_d     = acc_next;
                            ovf_out_d = ovf_next;
                            inv_out_d = inv_next;
                            acc_d     = '0;
                            ovf_d     = 1'b0;
                            inv_d     = 1'b0;
                            started_d = 1'b0;
                        end else begin
                            acc_d     = acc_next;
                            ovf_d     = ovf_next;
                            inv_d     = inv_next;
                            started_d = 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (ready_i) begin
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            inv_q     <= 1'b0;
            started_q <= 1'b0;
            sum_q     <= '0;
            ovf_out_q <= 1'b0;
            inv_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            inv_q     <= inv_d;
            started_q <= started_d;
            sum_q     <= sum_d;
            ovf_out_q <= ovf_out_d;
            inv_out_q <= inv_out_d;
        end
    end

    assign valid_o    = (state_q == HOLD);
    assign sum_o      = sum_q;
    assign overflow_o = ovf_out_q;
    assign invalid_o  = inv_out_q;
    assign busy_o     = started_q || (state_q == HOLD);

endmodule
